// File: rtl/dunc16_mem_resp.sv
// Word-addressed 16-bit memory responder with a 4-phase REQ/ACK handshake,
// programmable wait states and an out-of-range error flag qualifying ACK.
//
// state | meaning
// IDLE  | no access in flight; REQ accepted here and ADDR/WE/WDATA latched
// WAIT  | access accepted, counting down wait states
// DONE  | access complete; ACK high until REQ drops
module dunc16_mem_resp #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_BITS   = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] WDATA,
    output logic [15:0] RDATA,
    output logic        ACK,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic                   we_q;
    logic [15:0]            addr_q;
    logic [15:0]            wdata_q;

    logic                   finish;
    logic                   eff_we;
    logic [15:0]            eff_addr;
    logic [15:0]            eff_wdata;
    logic                   eff_oor;
    logic [ADDR_BITS-1:0]   eff_idx;
    logic                   ram_we;

    logic [15:0]            ram [2**ADDR_BITS];

    // With zero wait states the access completes on the acceptance edge, so
    // the live inputs stand in for the not-yet-latched copies.
    always_comb begin
        eff_we    = we_q;
        eff_addr  = addr_q;
        eff_wdata = wdata_q;
        if (state == IDLE) begin
            eff_we    = WE;
            eff_addr  = ADDR;
            eff_wdata = WDATA;
        end
        finish  = ((state == IDLE) && REQ && (WAIT_STATES == 0)) ||
                  ((state == WAIT) && (wait_cnt == 4'd0));
        eff_oor = (eff_addr >> ADDR_BITS) != 16'h0000;
        eff_idx = eff_addr[ADDR_BITS-1:0];
        ram_we  = finish && eff_we && !eff_oor;
    end

    // RAM contents survive reset; the RESET term only blocks writes while low.
    always_ff @(posedge CLK or negedge RESET) begin
        if (RESET && ram_we) begin
            ram[eff_idx] <= eff_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            RDATA    <= 16'h0000;
            ACK      <= 1'b0;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ) begin
                        addr_q  <= ADDR;
                        we_q    <= WE;
                        wdata_q <= WDATA;
                        if (WAIT_STATES != 0) begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                            BUSY     <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (!REQ) begin
                        state <= IDLE;
                        ACK   <= 1'b0;
                        BUSY  <= 1'b0;
                        ERR   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ACK   <= 1'b0;
                    BUSY  <= 1'b0;
                    ERR   <= 1'b0;
                end
            endcase

            if (finish) begin
                state <= DONE;
                ACK   <= 1'b1;
                BUSY  <= 1'b1;
                ERR   <= eff_oor;
                if (!eff_we) begin
                    RDATA <= eff_oor ? 16'hFFFF : ram[eff_idx];
                end
            end
        end
    end

endmodule

// File: doc/dunc16_mem_resp.md
DUNC16_MEM_RESP -- requirements
Module: dunc16_mem_resp

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning cycles inserted between request acceptance and ACK (legal 0..15).
REQ-002 SHALL have parameter ADDR_BITS, default 8, meaning implemented word-address bits (RAM depth 2**ADDR_BITS x 16).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port REQ  input  1  initiator access request, held high until ACK seen.
REQ-006 SHALL have port WE  input  1  1 = write, 0 = read; sampled with REQ.
REQ-007 SHALL have port ADDR  input  16  word address (MA value from the CPU).
REQ-008 SHALL have port WDATA  input  16  write data (MD value from the CPU).
REQ-009 SHALL have port RDATA  output  16  read data.
REQ-010 SHALL have port ACK  output  1  access complete.
REQ-011 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-012 SHALL have port ERR  output  1  qualifies ACK; high when address is out of range.

Function
REQ-013 SHALL implement states IDLE, WAIT, DONE.
REQ-014 In IDLE with REQ=1 at an edge: SHALL latch ADDR, WE and WDATA internally; later changes on those inputs SHALL NOT affect the access.
REQ-015 From IDLE on request: SHALL go to DONE if WAIT_STATES=0; otherwise go to WAIT with the wait counter loaded to WAIT_STATES-1.
REQ-016 In WAIT: counter SHALL decrement each cycle; at counter=0 SHALL go to DONE.
REQ-017 Latency: with the request accepted at edge N, ACK SHALL first be high after edge N+1+WAIT_STATES-1, i.e. N+WAIT_STATES for WAIT_STATES>=1, and N for WAIT_STATES=0.
REQ-018 ACK SHALL be high exactly while in DONE; DONE SHALL persist while REQ=1 and go to IDLE on the first edge with REQ=0 (4-phase handshake).
REQ-019 A new request SHALL be accepted only from IDLE; at least one idle cycle SHALL separate consecutive ACK pulses.
REQ-020 Range check: the address is out of range if any latched ADDR bit at or above ADDR_BITS is 1.
REQ-021 In-range write: RAM[ADDR[ADDR_BITS-1:0]] SHALL be written with WDATA exactly once, on the edge entering DONE; RDATA unchanged.
REQ-022 In-range read: RDATA SHALL be loaded from RAM on the edge entering DONE and held until the next completed read.
REQ-023 Out of range: no RAM write; RDATA SHALL load 16'hFFFF on reads; ERR SHALL be high throughout DONE.
REQ-024 ERR SHALL be 0 outside DONE.
REQ-025 Read of a location written by the immediately preceding access SHALL return the new data.
REQ-026 REQ dropping before ACK (protocol violation) SHALL be ignored; the access SHALL complete and DONE SHALL exit on the next edge.

Reset
REQ-027 RESET low SHALL immediately force IDLE, ACK=0, BUSY=0, ERR=0, RDATA=16'h0000 and wait counter=0.
REQ-028 RESET during WAIT SHALL abandon the access; a pending write SHALL NOT modify RAM.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 After RESET rises, a request SHALL be accepted at the first edge with REQ=1.

Verification
REQ-031 WAIT_STATES=1: write 16'h1234 to 0x0005, then read 0x0005 -> RDATA=16'h1234, ACK rises one edge after acceptance, ERR=0.
REQ-032 WAIT_STATES=0: read after write to 0x00FF -> ACK visible after the acceptance edge, correct data, BUSY high only while ACK is high.
REQ-033 Write to 0x0100 with ADDR_BITS=8 -> ERR=1 with ACK; a subsequent read of 0x0000 returns its prior value; a read of 0x0100 returns 16'hFFFF.
REQ-034 WAIT_STATES=3: hold REQ for 5 cycles after ACK -> ACK stays high 5 cycles, exactly one RAM write, IDLE one edge after REQ falls.
REQ-035 Assert RESET during WAIT of a write of 16'hBEEF to 0x0010 (prior value 16'h0001) -> outputs at reset values immediately; a later read of 0x0010 returns 16'h0001.
REQ-036 Change WDATA and ADDR after acceptance -> the originally latched values are written.
